fetch_ras: RTL and testbench

Return-address stack for the fetch unit. It consumes the per-bundle RAS control and branch PC that the fetch-stage branch decoder produces in F1. It supplies the predicted return target back to that decoder in F0. It also exports a checkpoint with every update so the backend can repair speculative corruption on a misprediction flush.

---
 rtl/fetch_ras.sv | 112 +++++++++++
 tb/tb_fetch_ras.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ras.sv
// fetch_ras: return-address stack for the fetch unit.
//
// The F1 branch decoder drives one RAS operation per bundle (push, pop or
// pop-then-push). The current top of stack is offered back to the decoder in
// F0 as the predicted return target. Each cycle the stack pointer and
// occupancy are exported as a checkpoint. On a misprediction flush the backend
// can hand a checkpoint back to repair speculative damage.
//
// Ports:
//   clk_i            clock
//   rst_n_i          asynchronous active-low reset
//   ras_vld_f1_i     F1 bundle carries a branch (already gated by flush)
//   ras_ctl_f1_i     00 none, 01 push, 10 pop, 11 pop-then-push
//   ras_dat_f1_i     branch PC; the pushed value is this PC + 4
//   flush_vld_i      backend redirect; blocks any F1 update this cycle
//   ras_rcv_vld_i    restore from ras_rcv_ckpt_i (only together with flush)
//   ras_rcv_ckpt_i   checkpoint to restore, {cnt, tos}
//   ras_rcv_dat_i    value written into the restored top entry
//   ras_pcdata_f0_o  predicted return address (top of stack, 0 when empty)
//   ras_ckpt_f1_o    {cnt, tos} before this cycle's update
//   ras_empty_o      stack holds no valid entries
module fetch_ras #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 ras_vld_f1_i,
    input  logic [1:0]           ras_ctl_f1_i,
    input  logic [63:0]          ras_dat_f1_i,
    input  logic                 flush_vld_i,
    input  logic                 ras_rcv_vld_i,
    input  logic [2*PTR_W:0]     ras_rcv_ckpt_i,
    input  logic [63:0]          ras_rcv_dat_i,
    output logic [63:0]          ras_pcdata_f0_o,
    output logic [2*PTR_W:0]     ras_ckpt_f1_o,
    output logic                 ras_empty_o
);

    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] CTL_PUSH     = 2'b01;
    localparam logic [1:0] CTL_POP      = 2'b10;
    localparam logic [1:0] CTL_POP_PUSH = 2'b11;

    logic [63:0]      stack [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [PTR_W:0]   cnt;

    logic [PTR_W-1:0] rcv_tos;
    logic [PTR_W:0]   rcv_cnt;
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] tos_dec;
    logic [63:0]      push_val;
    logic             is_empty;

    assign rcv_tos  = ras_rcv_ckpt_i[PTR_W-1:0];
    assign rcv_cnt  = ras_rcv_ckpt_i[2*PTR_W:PTR_W];
    // DEPTH is a power of two, so plain PTR_W-bit arithmetic wraps the pointer.
    assign tos_inc  = tos + 1'b1;
    assign tos_dec  = tos - 1'b1;
    assign push_val = ras_dat_f1_i + 64'd4;
    assign is_empty = (cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tos <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (flush_vld_i) begin
            // A flush always wins over F1; without a checkpoint the state is held.
            if (ras_rcv_vld_i) begin
                tos            <= rcv_tos;
                cnt            <= rcv_cnt;
                stack[rcv_tos] <= ras_rcv_dat_i;
            end
        end else if (ras_vld_f1_i) begin
            case (ras_ctl_f1_i)
                CTL_PUSH: begin
                    // When full, the write lands on the oldest entry.
                    tos            <= tos_inc;
                    stack[tos_inc] <= push_val;
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CTL_POP: begin
                    if (!is_empty) begin
                        tos <= tos_dec;
                        cnt <= cnt - 1'b1;
                    end
                end
                CTL_POP_PUSH: begin
                    // The pop and the push cancel out, leaving a replaced top.
                    stack[tos] <= push_val;
                    if (is_empty) begin
                        cnt <= (PTR_W + 1)'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ras_pcdata_f0_o = is_empty ? 64'h0 : stack[tos];
    assign ras_ckpt_f1_o   = {cnt, tos};
    assign ras_empty_o     = is_empty;

endmodule

// File: tb/tb_fetch_ras.sv
module tb_fetch_ras;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic               clk_i = 1'b0;
    logic               rst_n_i;
    logic               ras_vld_f1_i;
    logic [1:0]         ras_ctl_f1_i;
    logic [63:0]        ras_dat_f1_i;
    logic               flush_vld_i;
    logic               ras_rcv_vld_i;
    logic [2*PTR_W:0]   ras_rcv_ckpt_i;
    logic [63:0]        ras_rcv_dat_i;
    logic [63:0]        ras_pcdata_f0_o;
    logic [2*PTR_W:0]   ras_ckpt_f1_o;
    logic               ras_empty_o;

    int vectors    = 0;
    int miscompares = 0;

    logic [2*PTR_W:0] saved_ckpt;

    always #5 clk_i = ~clk_i;

    fetch_ras #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .ras_vld_f1_i    (ras_vld_f1_i),
        .ras_ctl_f1_i    (ras_ctl_f1_i),
        .ras_dat_f1_i    (ras_dat_f1_i),
        .flush_vld_i     (flush_vld_i),
        .ras_rcv_vld_i   (ras_rcv_vld_i),
        .ras_rcv_ckpt_i  (ras_rcv_ckpt_i),
        .ras_rcv_dat_i   (ras_rcv_dat_i),
        .ras_pcdata_f0_o (ras_pcdata_f0_o),
        .ras_ckpt_f1_o   (ras_ckpt_f1_o),
        .ras_empty_o     (ras_empty_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ckpt expected as {cnt, tos}
    task automatic check_state(input string tag, input logic [63:0] pc,
                               input logic empty, input int cnt, input int tos);
        logic [2*PTR_W:0] ck;
        ck = {4'(cnt), 3'(tos)};
        check({tag, ".pc"}, ras_pcdata_f0_o, pc);
        check({tag, ".empty"}, {63'd0, ras_empty_o}, {63'd0, empty});
        check({tag, ".ckpt"}, {57'd0, ras_ckpt_f1_o}, {57'd0, ck});
    endtask

    task automatic idle();
        ras_vld_f1_i   = 1'b0;
        ras_ctl_f1_i   = 2'b00;
        ras_dat_f1_i   = 64'h0;
        flush_vld_i    = 1'b0;
        ras_rcv_vld_i  = 1'b0;
        ras_rcv_ckpt_i = '0;
        ras_rcv_dat_i  = 64'h0;
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic f1(input logic [1:0] ctl, input logic [63:0] dat);
        ras_vld_f1_i = 1'b1;
        ras_ctl_f1_i = ctl;
        ras_dat_f1_i = dat;
        @(posedge clk_i);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst_n_i = 1'b0;
        #12;
        check_state("reset", 64'h0, 1'b1, 0, 0);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // two pushes
        f1(2'b01, 64'h1000);
        check_state("push1", 64'h1004, 1'b0, 1, 1);
        f1(2'b01, 64'h2000);
        check_state("push2", 64'h2004, 1'b0, 2, 2);
        f1(2'b10, 64'h0);
        check_state("pop1", 64'h1004, 1'b0, 1, 1);
        f1(2'b10, 64'h0);
        check_state("pop2", 64'h0, 1'b1, 0, 0);

        // overflow: 9 pushes, the k=0 entry is overwritten
        for (int k = 0; k <= DEPTH; k++) begin
            f1(2'b01, 64'(k * 'h100));
        end
        check_state("ovf_full", 64'h804, 1'b0, 8, 1);
        for (int j = 0; j < DEPTH; j++) begin
            check("ovf_seq", ras_pcdata_f0_o, 64'(64'h804 - j * 'h100));
            f1(2'b10, 64'h0);
        end
        check_state("ovf_drained", 64'h0, 1'b1, 0, 1);

        // underflow ignored
        f1(2'b10, 64'h0);
        check_state("underflow", 64'h0, 1'b1, 0, 1);
        f1(2'b01, 64'h40);
        check_state("after_uf_push", 64'h44, 1'b0, 1, 2);
        f1(2'b10, 64'h0);
        check_state("uf_pop", 64'h0, 1'b1, 0, 1);

        // pop-then-push
        f1(2'b01, 64'h1000);
        check_state("pp_push", 64'h1004, 1'b0, 1, 2);
        f1(2'b11, 64'h3000);
        check_state("pp", 64'h3004, 1'b0, 1, 2);
        f1(2'b10, 64'h0);
        check_state("pp_pop", 64'h0, 1'b1, 0, 1);
        f1(2'b11, 64'h500);
        check_state("pp_empty", 64'h504, 1'b0, 1, 1);
        f1(2'b10, 64'h0);
        check_state("pp_empty_pop", 64'h0, 1'b1, 0, 0);

        // push value wraps modulo 2^64
        f1(2'b01, 64'hFFFF_FFFF_FFFF_FFFE);
        check_state("wrap64", 64'h2, 1'b0, 1, 1);
        f1(2'b10, 64'h0);
        check_state("wrap64_pop", 64'h0, 1'b1, 0, 0);

        // checkpoint and recovery
        f1(2'b01, 64'hA0);
        f1(2'b01, 64'hB0);
        f1(2'b01, 64'hC0);
        check_state("ck_cap", 64'hC4, 1'b0, 3, 3);
        saved_ckpt = ras_ckpt_f1_o;
        f1(2'b01, 64'hD0);
        f1(2'b01, 64'hE0);
        check_state("ck_spec", 64'hE4, 1'b0, 5, 5);
        flush_vld_i    = 1'b1;
        ras_rcv_vld_i  = 1'b1;
        ras_rcv_ckpt_i = saved_ckpt;
        ras_rcv_dat_i  = 64'hBEEF;
        f1(2'b01, 64'hF00);
        check_state("ck_restore", 64'hBEEF, 1'b0, 3, 3);

        // flush alone holds state and drops the push
        flush_vld_i = 1'b1;
        f1(2'b01, 64'h700);
        check_state("flush_hold", 64'hBEEF, 1'b0, 3, 3);

        // recovery request without flush is ignored
        ras_rcv_vld_i  = 1'b1;
        ras_rcv_ckpt_i = '0;
        ras_rcv_dat_i  = 64'h1234;
        @(posedge clk_i);
        #1;
        idle();
        check_state("rcv_noflush", 64'hBEEF, 1'b0, 3, 3);

        // pop after restore exposes the entry below the restored top
        f1(2'b10, 64'h0);
        check_state("ck_pop", 64'hB4, 1'b0, 2, 2);

        // reach cnt = 4, then reset asynchronously between edges
        f1(2'b01, 64'h900);
        f1(2'b01, 64'hF00);
        check_state("pre_rst", 64'hF04, 1'b0, 4, 4);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_state("async_rst", 64'h0, 1'b1, 0, 0);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_state("post_rst_idle", 64'h0, 1'b1, 0, 0);
        f1(2'b01, 64'h40);
        check_state("post_rst_push", 64'h44, 1'b0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
